// File: rtl/subunit_rr_scheduler.sv
// Round-robin owner scheduler: one registered one-hot grant, held until done/abandon, then a dead cycle.
// Optional forced release after MAX_HOLD owned cycles when SUBUNIT_SCHED_TIMEOUT_EN is defined.
module subunit_rr_scheduler #(
    parameter int NUM_REQ  = 5,
    parameter int ID_W     = 3,
    parameter int MAX_HOLD = 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] done,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_id,
    output logic               busy,
    output logic               timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_REL  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [ID_W-1:0]    r_gnt_id;
    logic [ID_W-1:0]    r_last;
    logic [ID_W-1:0]    w_winner;
    logic               w_norm_rel;
    logic               w_timeout;
    logic               w_release;
    logic               w_tout_flag;

    if ((2 ** ID_W) < NUM_REQ || NUM_REQ < 2 || MAX_HOLD < 1) begin : g_param_check
        $error("subunit_rr_scheduler: illegal parameter combination");
    end

    // First requester strictly after the last winner, wrapping modulo NUM_REQ.
    function automatic logic [ID_W-1:0] f_pick(input logic [NUM_REQ-1:0] r,
                                               input logic [ID_W-1:0]    last);
        logic [ID_W-1:0] idx;
        logic [ID_W-1:0] win;
        logic            found;
        idx   = last;
        win   = '0;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (idx == ID_W'(NUM_REQ - 1)) ? '0 : idx + 1'b1;
            if (!found && r[idx]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

    assign w_winner   = f_pick(req, r_last);
    assign w_norm_rel = (|(done & r_gnt)) | ~(|(req & r_gnt));
    assign w_release  = (r_state == S_OWN) && (w_norm_rel || w_timeout);

`ifdef SUBUNIT_SCHED_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD + 1);

    logic [CNT_W-1:0] r_hold;
    logic             r_tout;

    // A timeout only counts when no ordinary release happens on the same edge.
    assign w_timeout   = !w_norm_rel && (r_hold == CNT_W'(MAX_HOLD - 1));
    assign w_tout_flag = r_tout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hold <= '0;
            r_tout <= 1'b0;
        end else begin
            r_tout <= (r_state == S_OWN) && w_timeout;
            if (r_state == S_IDLE) begin
                r_hold <= '0;
            end else if (r_state == S_OWN && !w_release) begin
                r_hold <= r_hold + 1'b1;
            end
        end
    end
`else
    assign w_timeout   = 1'b0;
    assign w_tout_flag = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (|req) w_state_nxt = S_OWN;
            S_OWN:   if (w_release) w_state_nxt = S_REL;
            S_REL:   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Reset pointer at NUM_REQ-1 so requester 0 wins the first scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_last   <= ID_W'(NUM_REQ - 1);
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (|req) begin
                        r_gnt    <= NUM_REQ'(1) << w_winner;
                        r_gnt_id <= w_winner;
                        r_last   <= w_winner;
                    end
                end
                S_OWN: begin
                    if (w_release) begin
                        r_gnt    <= '0;
                        r_gnt_id <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        gnt         = r_gnt;
        gnt_id      = r_gnt_id;
        busy        = |r_gnt;
        timeout_err = w_tout_flag;
    end

endmodule

// File: tb/tb_subunit_rr_scheduler.sv
// Directed plus randomized bench for subunit_rr_scheduler against a cycle-level owner/rotation model.
module tb_subunit_rr_scheduler;

    localparam int N   = 5;
    localparam int IDW = 3;
    localparam int MH  = 8;
`ifdef SUBUNIT_SCHED_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   done = '0;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout_err;

    int n_cmp = 0;
    int n_err = 0;

    // Model: current owner (-1 none), pending dead cycle, rotation pointer, owned-cycle count.
    int m_owner;
    int m_dead;
    int m_last;
    int m_hold;
    bit m_tout;

    int order[$];
    int zc;
    bit prev_nz;
    int n_to;

    subunit_rr_scheduler #(
        .NUM_REQ (N),
        .ID_W    (IDW),
        .MAX_HOLD(MH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .done       (done),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

    function automatic bit bit_of(input logic [N-1:0] v, input int i);
        logic [IDW-1:0] k;
        k = i[IDW-1:0];
        return v[k];
    endfunction

    function automatic int pick(input logic [N-1:0] r, input int last);
        for (int k = 1; k <= N; k++) begin
            if (bit_of(r, (last + k) % N)) return (last + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_dead  = 0;
        m_last  = N - 1;
        m_hold  = 0;
        m_tout  = 1'b0;
    endtask

    task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] d);
        bit norm;
        m_tout = 1'b0;
        if (m_owner >= 0) begin
            norm = bit_of(d, m_owner) || !bit_of(r, m_owner);
            if (norm || (TO_EN && m_hold == MH - 1)) begin
                m_tout  = !norm;
                m_owner = -1;
                m_dead  = 1;
            end else begin
                m_hold++;
            end
        end else if (m_dead != 0) begin
            m_dead = 0;
        end else if (r != '0) begin
            m_owner = pick(r, m_last);
            m_last  = m_owner;
            m_hold  = 0;
        end
    endtask

    task automatic check(input string tag);
        logic [N-1:0]   eg;
        logic [IDW-1:0] eid;
        logic           eb;
        eg  = '0;
        eid = '0;
        eb  = 1'b0;
        if (m_owner >= 0) begin
            eg  = N'(1) << m_owner;
            eid = IDW'(m_owner);
            eb  = 1'b1;
        end
        n_cmp++;
        assert (gnt === eg) else begin
            n_err++;
            $error("FAIL %s gnt got %b exp %b", tag, gnt, eg);
        end
        n_cmp++;
        assert (gnt_id === eid) else begin
            n_err++;
            $error("FAIL %s gnt_id got %0d exp %0d", tag, gnt_id, eid);
        end
        n_cmp++;
        assert (busy === eb) else begin
            n_err++;
            $error("FAIL %s busy got %b exp %b", tag, busy, eb);
        end
        n_cmp++;
        assert (timeout_err === m_tout) else begin
            n_err++;
            $error("FAIL %s timeout_err got %b exp %b", tag, timeout_err, m_tout);
        end
        n_cmp++;
        assert ($onehot0(gnt)) else begin
            n_err++;
            $error("FAIL %s onehot0 gnt got %b exp at most one bit", tag, gnt);
        end
    endtask

    task automatic step(input string tag);
        logic [N-1:0] r;
        logic [N-1:0] d;
        r = req;
        d = done;
        @(posedge clk);
        #1;
        if (rst_n) model_edge(r, d);
        check(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        model_reset();
        #1;
        check(tag);
        step(tag);
        rst_n = 1'b1;
    endtask

    initial begin
        model_reset();
        #1;
        do_reset("reset");
        step("reset_idle");

        // single requester, latency and release
        req = 5'b00100;
        step("t1_grant");
        step("t1_hold");
        done = 5'b00100;
        step("t1_release");
        done = '0;
        req  = '0;
        step("t1_dead");
        step("t1_idle");

        // all requesting, done three cycles after each grant
        do_reset("t2_reset");
        req     = 5'b11111;
        zc      = 0;
        prev_nz = 1'b0;
        for (int c = 0; c < 30; c++) begin
            done = (m_owner >= 0 && m_hold == 2) ? (N'(1) << m_owner) : '0;
            step("t2_rr");
            if (gnt !== '0 && !prev_nz) begin
                if (order.size() > 0) begin
                    n_cmp++;
                    assert (zc === 2) else begin
                        n_err++;
                        $error("FAIL t2_gap got %0d exp 2", zc);
                    end
                end
                order.push_back(int'(gnt_id));
                zc = 0;
            end else if (gnt === '0) begin
                zc++;
            end
            prev_nz = (gnt !== '0);
        end
        n_cmp++;
        assert (order.size() >= 6) else begin
            n_err++;
            $error("FAIL t2_count got %0d exp >=6", order.size());
        end
        for (int i = 0; i < 6 && i < order.size(); i++) begin
            n_cmp++;
            assert (order[i] === i % N) else begin
                n_err++;
                $error("FAIL t2_order[%0d] got %0d exp %0d", i, order[i], i % N);
            end
        end
        done = '0;
        req  = '0;
        repeat (4) step("t2_drain");

        // foreign done ignored, abandon releases, rotation continues
        req = 5'b01010;
        step("t3_grant");
        done = 5'b01000;
        step("t3_ignore");
        n_cmp++;
        assert (gnt === 5'b00010) else begin
            n_err++;
            $error("FAIL t3_ignore_gnt got %b exp 00010", gnt);
        end
        done = '0;
        req  = 5'b01100;
        step("t3_abandon");
        step("t3_dead");
        step("t3_next");
        n_cmp++;
        assert (gnt_id === 3'd2) else begin
            n_err++;
            $error("FAIL t3_next_id got %0d exp 2", gnt_id);
        end
        req = '0;
        repeat (3) step("t3_drain");

        // pointer wrap around last_winner = 4
        req = 5'b10000;
        step("t4_grant4");
        req = '0;
        repeat (3) step("t4_drain");
        req = 5'b10001;
        step("t4_wrap");
        n_cmp++;
        assert (gnt === 5'b00001) else begin
            n_err++;
            $error("FAIL t4_wrap_gnt got %b exp 00001", gnt);
        end
        done = 5'b00001;
        step("t4_release");
        done = '0;
        step("t4_dead");
        step("t4_regrant");
        n_cmp++;
        assert (gnt === 5'b10000) else begin
            n_err++;
            $error("FAIL t4_regrant_gnt got %b exp 10000", gnt);
        end
        req = 5'b01000;
        step("t4_abandon");
        step("t4_dead2");
        step("t4_grant3");

        // asynchronous reset while 3 owns
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t5_async");
        n_cmp++;
        assert (gnt === '0 && busy === 1'b0) else begin
            n_err++;
            $error("FAIL t5_async_drop got gnt %b busy %b exp 0 0", gnt, busy);
        end
        step("t5_hold_reset");
        req   = 5'b11000;
        rst_n = 1'b1;
        step("t5_restart");
        n_cmp++;
        assert (gnt_id === 3'd3) else begin
            n_err++;
            $error("FAIL t5_restart_id got %0d exp 3", gnt_id);
        end

        // owner never signals done
        n_to = 0;
`ifdef SUBUNIT_SCHED_TIMEOUT_EN
        repeat (7) step("t6_hold");
        step("t6_force");
        n_cmp++;
        assert (timeout_err === 1'b1 && gnt === '0) else begin
            n_err++;
            $error("FAIL t6_force got tout %b gnt %b exp 1 00000", timeout_err, gnt);
        end
        step("t6_dead");
        step("t6_next");
        n_cmp++;
        assert (gnt === 5'b10000) else begin
            n_err++;
            $error("FAIL t6_next_gnt got %b exp 10000", gnt);
        end
`else
        for (int c = 0; c < 100; c++) begin
            step("t6_hold");
            if (timeout_err === 1'b1) n_to++;
        end
        n_cmp++;
        assert (gnt === 5'b01000 && n_to === 0) else begin
            n_err++;
            $error("FAIL t6_held got gnt %b pulses %0d exp 01000 0", gnt, n_to);
        end
`endif

        // randomized traffic
        req  = '0;
        done = '0;
        do_reset("t7_reset");
        for (int c = 0; c < 400; c++) begin
            req = N'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) req = req | (N'(1) << m_owner);
            done = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
            step("t7_rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/subunit_rr_scheduler.md
Name: subunit_rr_scheduler

Overview:
- Round-robin scheduler sharing one resource slot among the five leaf sub-instances of a hierarchy node.
- Each sub-instance raises a request; the scheduler grants exactly one at a time with a registered one-hot grant, holds it until the owner signals done, then rotates priority.
- Sits beside the node's instance list and sequences sub-instance access so the shared resource is never double-owned.

Parameters:
- NUM_REQ, 5, number of requesters (2..16).
- ID_W, 3, width of gnt_id; must satisfy 2**ID_W >= NUM_REQ.
- MAX_HOLD, 64, hold-cycle limit; used only when the timeout feature is enabled.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- req  input  NUM_REQ  per-requester request level; requester holds it until granted and done.
- done  input  NUM_REQ  per-requester one-cycle release pulse.
- gnt  output  NUM_REQ  registered one-hot grant, or all zero.
- gnt_id  output  ID_W  index of the current owner; 0 when idle.
- busy  output  1  high while any grant is held.
- timeout_err  output  1  one-cycle pulse on forced release (feature only; tied 0 otherwise).

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, gnt=0, gnt_id=0, busy=0, timeout_err=0, last_winner=NUM_REQ-1 so requester 0 has top priority first.
- The FSM has three states: IDLE, OWN and RELEASE.
- IDLE, req==0: stay in IDLE with all outputs low.
- IDLE, req!=0: pick the first set bit scanning from last_winner+1 upward, wrapping modulo NUM_REQ.
  - On the next edge: gnt=onehot(winner), gnt_id=winner, busy=1, last_winner=winner, go to OWN.
  - Request-to-grant latency is 1 cycle.
- OWN: gnt is stable. On the edge where done[gnt_id]=1, or req[gnt_id]=0 (abandon), go to RELEASE and clear gnt, gnt_id and busy on that edge.
- done bits from non-owners are ignored in every state. done while in IDLE is ignored.
- If done[owner] and a drop of req[owner] occur in the same cycle, there is a single release.
- RELEASE: one mandatory dead cycle with gnt=0, then go to IDLE. Minimum grant-to-grant gap is 2 cycles (release edge plus dead cycle); no overlap is possible.
- Fairness:
  - With all requests continuously asserted, grants cycle 0,1,2,3,4,0,…
  - A requester that re-requests right after its release waits behind every other pending requester.
- Priority pointer (wrap-around): after last_winner=NUM_REQ-1 the scan starts at 0.
- A request arriving mid-OWN is only evaluated at the next IDLE.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_id==index of the set gnt bit whenever busy=1.
  - busy==|gnt.
- Reset asserted mid-OWN drops the grant immediately, asynchronously. After deassert, arbitration restarts from requester 0.

Optional Feature:
- Macro: SUBUNIT_SCHED_TIMEOUT_EN.
- Defined:
  - A hold counter clears on each grant and increments every OWN cycle.
  - When it reaches MAX_HOLD-1 without a release, the grant is force-released on the next edge (same path as a normal release), and timeout_err pulses high for exactly that cycle.
  - The forced owner is treated as the last winner for rotation.
- Undefined: no counter exists, timeout_err is tied 0, and a grant is held indefinitely until done or abandon.

Test Plan:
- Reset then req=5'b00100 → gnt=5'b00100, gnt_id=2, busy=1 exactly 1 cycle later. done[2] pulse → gnt=0 on that edge, then IDLE after 1 dead cycle.
- req=5'b11111 held, each owner pulses done 3 cycles after its grant → grant order 0,1,2,3,4,0. Gap between grants is 2 cycles. gnt is never non-one-hot.
- Owner 1 granted, done[3] pulsed → ignored, gnt stays 5'b00010. Then req[1] dropped → release and rotation continues from 2.
- last_winner=4, req=5'b10001 → grant goes to 0. Next IDLE with req still 5'b10001 → grant goes to 4.
- Reset asserted while gnt=5'b01000 → gnt=0, busy=0 asynchronously, without waiting for a clock edge. After release with req=5'b11000 → grant goes to 3.
- With SUBUNIT_SCHED_TIMEOUT_EN and MAX_HOLD=8, owner never pulses done → forced release after 8 OWN cycles, timeout_err high for 1 cycle, next requester is granted. Without the macro, the grant is still held at cycle 100.
